// File: rtl/pcpi_arbiter_pkg.sv
// Shared constants and types for the PCPI co-processor arbiter.
// Decoding, slave numbering and FSM states live here so the top and decoder agree.
package pcpi_arbiter_pkg;

  localparam logic [6:0] OP_FP      = 7'b1010011;
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] MULDIV     = 7'b0000001;

  localparam logic       SLV_FPU    = 1'b0;
  localparam logic       SLV_MULDIV = 1'b1;
  localparam int         NUM_SLV    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Extracts slave idx's 32-bit lane from the packed two-slave result bus.
  function automatic logic [31:0] slv_slice(input logic [63:0] bus, input logic idx);
    return idx ? bus[63:32] : bus[31:0];
  endfunction

endpackage

// File: rtl/pcpi_arbiter_decode.sv
// Combinational instruction decoder: decides whether a PCPI instruction is
// claimed and which slave (FPU or mul/div) executes it.
module pcpi_decode
  import pcpi_arbiter_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  output logic       claimed_o,
  output logic       sel_o
);

  always_comb begin
    claimed_o = 1'b0;
    sel_o     = SLV_FPU;
    if (opcode_i == OP_FP) begin
      claimed_o = 1'b1;
      sel_o     = SLV_FPU;
    end else if ((opcode_i == OP_REG) && (funct7_i == MULDIV)) begin
      claimed_o = 1'b1;
      sel_o     = SLV_MULDIV;
    end
  end

endmodule

// File: rtl/pcpi_arbiter.sv
// PCPI arbiter: routes claimed core instructions to one of two co-processor
// slaves, returns the result as a one-cycle strobe, and aborts stuck slaves.
module pcpi_arbiter
  import pcpi_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clkIn,
  input  logic        rstLowIn,
  input  logic        pcpiValidIn,
  input  logic [31:0] pcpiInstIn,
  input  logic [31:0] pcpiRs1In,
  input  logic [31:0] pcpiRs2In,
  output logic        pcpiWrOut,
  output logic [31:0] pcpiRdOut,
  output logic        pcpiWaitOut,
  output logic        pcpiReadyOut,
  output logic [1:0]  slvValidOut,
  output logic [31:0] slvInstOut,
  output logic [31:0] slvRs1Out,
  output logic [31:0] slvRs2Out,
  input  logic [1:0]  slvWrIn,
  input  logic [63:0] slvRdIn,
  input  logic [1:0]  slvReadyIn,
  output logic        timeoutOut
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] rd_q, rd_d;
  logic        timeout_q, timeout_d;

  logic        dec_claimed;
  logic        dec_sel;
  logic        busy;
  logic        resp;
  logic        sel_ready;

  pcpi_decode u_decode (
    .opcode_i  (pcpiInstIn[6:0]),
    .funct7_i  (pcpiInstIn[31:25]),
    .claimed_o (dec_claimed),
    .sel_o     (dec_sel)
  );

  // Only the selected slave's ready is ever looked at.
  assign sel_ready = slvReadyIn[sel_q];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    inst_d    = inst_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (pcpiValidIn && dec_claimed) begin
          sel_d   = dec_sel;
          inst_d  = pcpiInstIn;
          rs1_d   = pcpiRs1In;
          rs2_d   = pcpiRs2In;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Core withdrawal beats a late slave answer; ready beats timeout.
        if (!pcpiValidIn) begin
          state_d = IDLE;
        end else if (sel_ready) begin
          wr_d    = slvWrIn[sel_q];
          rd_d    = slv_slice(slvRdIn, sel_q);
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!pcpiValidIn) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      state_q   <= IDLE;
      sel_q     <= SLV_FPU;
      inst_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      inst_q    <= inst_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign resp = (state_q == RESP);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv_valid
      assign slvValidOut[gi] = busy && (sel_q == 1'(gi));
    end
  endgenerate

  // Slave buses are masked outside BUSY so idle/drain cycles present all zeros.
  assign slvInstOut   = busy ? inst_q : '0;
  assign slvRs1Out    = busy ? rs1_q  : '0;
  assign slvRs2Out    = busy ? rs2_q  : '0;
  assign pcpiWaitOut  = busy;
  assign pcpiReadyOut = resp;
  assign pcpiWrOut    = resp & wr_q;
  assign pcpiRdOut    = resp ? rd_q : '0;
  assign timeoutOut   = timeout_q;

endmodule

// File: tb/tb_pcpi_arbiter.sv
// Self-checking bench for pcpi_arbiter: a cycle-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_pcpi_arbiter;

  localparam int TO = 64;
  localparam int PH_IDLE = 0, PH_BUSY = 1, PH_RESP = 2, PH_DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] inst, rs1, rs2;
  logic [1:0]  slv_wr, slv_ready;
  logic [63:0] slv_rd;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, tout;
  logic [31:0] pcpi_rd, slv_inst, slv_rs1, slv_rs2;
  logic [1:0]  slv_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_phase = PH_IDLE;
  int          m_sel   = 0;
  int          m_age   = 0;
  logic [31:0] m_inst  = '0, m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic        m_wr    = 1'b0;
  logic        m_tout  = 1'b0;

  pcpi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clkIn        (clk),
    .rstLowIn     (rst_n),
    .pcpiValidIn  (valid),
    .pcpiInstIn   (inst),
    .pcpiRs1In    (rs1),
    .pcpiRs2In    (rs2),
    .pcpiWrOut    (pcpi_wr),
    .pcpiRdOut    (pcpi_rd),
    .pcpiWaitOut  (pcpi_wait),
    .pcpiReadyOut (pcpi_ready),
    .slvValidOut  (slv_valid),
    .slvInstOut   (slv_inst),
    .slvRs1Out    (slv_rs1),
    .slvRs2Out    (slv_rs2),
    .slvWrIn      (slv_wr),
    .slvRdIn      (slv_rd),
    .slvReadyIn   (slv_ready),
    .timeoutOut   (tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -1 = unclaimed, otherwise the slave number that owns the instruction.
  function automatic int claim_of(input logic [31:0] i);
    if (i[6:0] == 7'h53) return 0;
    if ((i & 32'hFE00_007F) == 32'h0200_0033) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_age   = 0;
    m_tout  = 1'b0;
  endtask

  // Advance the model over the coming rising edge using the inputs it will sample.
  task automatic model_step();
    int c;
    c = claim_of(inst);
    case (m_phase)
      PH_IDLE: if (valid && c >= 0) begin
        m_phase = PH_BUSY; m_sel = c; m_age = 0;
        m_inst = inst; m_rs1 = rs1; m_rs2 = rs2;
      end
      PH_BUSY: begin
        if (!valid) m_phase = PH_IDLE;
        else if (slv_ready[m_sel]) begin
          m_wr    = slv_wr[m_sel];
          m_rd    = (m_sel == 1) ? slv_rd[63:32] : slv_rd[31:0];
          m_phase = PH_RESP;
        end else if (m_age == TO - 1) begin
          m_tout  = 1'b1;
          m_phase = PH_DRAIN;
        end else m_age++;
      end
      PH_RESP: m_phase = PH_DRAIN;
      default: if (!valid) m_phase = PH_IDLE;
    endcase
  endtask

  // Every-cycle comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    logic       e_busy, e_resp;
    logic [1:0] e_sv;
    if (!rst_n) model_reset();
    e_busy = (m_phase == PH_BUSY);
    e_resp = (m_phase == PH_RESP);
    e_sv   = e_busy ? (2'b01 << m_sel) : 2'b00;
    check("m_wait",     pcpi_wait,  e_busy);
    check("m_ready",    pcpi_ready, e_resp);
    check("m_slvvalid", slv_valid,  e_sv);
    check("m_wr",       pcpi_wr,    e_resp ? m_wr : 1'b0);
    check("m_rd",       pcpi_rd,    e_resp ? m_rd : 32'd0);
    check("m_slvinst",  slv_inst,   e_busy ? m_inst : 32'd0);
    check("m_slvrs1",   slv_rs1,    e_busy ? m_rs1 : 32'd0);
    check("m_slvrs2",   slv_rs2,    e_busy ? m_rs2 : 32'd0);
    check("m_timeout",  tout,       m_tout);
    if (rst_n) model_step();
  end

  initial begin
    logic        saw;
    logic [31:0] tmp;
    int          len, gap;
    bit          quiet, do_rst;

    rst_n = 1'b0; valid = 1'b0; inst = '0; rs1 = '0; rs2 = '0;
    slv_wr = '0; slv_rd = '0; slv_ready = '0;
    tick(); tick();
    check("rst_wait", pcpi_wait, 1'b0);
    check("rst_slvvalid", slv_valid, 2'b00);
    check("rst_timeout", tout, 1'b0);
    rst_n = 1'b1;
    tick();

    // FADD.S to the FPU, ready after five busy cycles.
    inst = 32'h0020F053; rs1 = 32'h3F800000; rs2 = 32'h40000000; valid = 1'b1;
    slv_wr = 2'b01; slv_rd = {32'hDEADBEEF, 32'h40400000};
    saw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      saw |= slv_valid[1];
      case (k)
        1: begin check("fadd_wait", pcpi_wait, 1'b1); check("fadd_sv", slv_valid, 2'b01); end
        5: begin check("fadd_rdy_early", pcpi_ready, 1'b0); slv_ready = 2'b01; end
        6: begin
          slv_ready = 2'b00;
          check("fadd_rdy", pcpi_ready, 1'b1);
          check("fadd_rd", pcpi_rd, 32'h40400000);
          check("fadd_wr", pcpi_wr, 1'b1);
          valid = 1'b0;
        end
        7: check("fadd_rdy_once", pcpi_ready, 1'b0);
        default: ;
      endcase
    end
    check("fadd_no_slv1", saw, 1'b0);
    $display("txn FADD.S done");

    // MUL to the mul/div slave, ready after one cycle.
    inst = 32'h022081B3; rs1 = 32'd2; rs2 = 32'd3; valid = 1'b1;
    slv_wr = 2'b10; slv_rd = {32'd6, 32'h12345678};
    tick();
    check("mul_sv", slv_valid, 2'b10);
    slv_ready = 2'b10;
    tick();
    slv_ready = 2'b00;
    check("mul_rdy", pcpi_ready, 1'b1);
    check("mul_rd", pcpi_rd, 32'd6);
    valid = 1'b0;
    tick(); tick();
    $display("txn MUL done");

    // ADD is not claimed.
    inst = 32'h002081B3; valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("add_wait", pcpi_wait, 1'b0);
      check("add_sv", slv_valid, 2'b00);
    end
    valid = 1'b0;
    tick();
    $display("txn ADD done");

    // FPU never answers: abort after TO busy cycles.
    inst = 32'h0020F053; valid = 1'b1; saw = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      saw |= pcpi_ready;
      if (k == 64) begin check("to_wait_last", pcpi_wait, 1'b1); check("to_flag_pre", tout, 1'b0); end
      if (k == 65) begin
        check("to_wait_drop", pcpi_wait, 1'b0);
        check("to_flag", tout, 1'b1);
        check("to_sv", slv_valid, 2'b00);
      end
    end
    valid = 1'b0;
    tick(); tick(); tick();
    check("to_sticky", tout, 1'b1);
    check("to_no_ready", saw, 1'b0);
    $display("txn FPU timeout done");

    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    check("to_cleared", tout, 1'b0);

    // Stray slave1 ready, then slave0 ready on the final timeout cycle.
    inst = 32'h0020F053; valid = 1'b1; slv_wr = 2'b01;
    slv_rd = {32'h00000BAD, 32'h3F800000};
    for (int k = 1; k <= 67; k++) begin
      tick();
      case (k)
        3:  slv_ready = 2'b10;
        4:  begin slv_ready = 2'b00; check("stray_busy", pcpi_wait, 1'b1); end
        64: slv_ready = 2'b01;
        65: begin
          slv_ready = 2'b00;
          check("race_rdy", pcpi_ready, 1'b1);
          check("race_rd", pcpi_rd, 32'h3F800000);
          check("race_tout", tout, 1'b0);
          valid = 1'b0;
        end
        66: check("race_tout_after", tout, 1'b0);
        default: ;
      endcase
    end
    $display("txn ready-vs-timeout done");

    // Reset in the middle of a MUL, then a fresh MUL.
    inst = 32'h022081B3; valid = 1'b1;
    tick(); tick();
    check("rstmid_busy", pcpi_wait, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_wait", pcpi_wait, 1'b0);
    check("rstmid_sv", slv_valid, 2'b00);
    check("rstmid_inst", slv_inst, 32'd0);
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rstmid_idle", pcpi_wait, 1'b0);
    valid = 1'b1; slv_wr = 2'b10; slv_rd = {32'd42, 32'd0};
    tick();
    check("post_rst_sv", slv_valid, 2'b10);
    slv_ready = 2'b10;
    tick();
    slv_ready = 2'b00;
    check("post_rst_rdy", pcpi_ready, 1'b1);
    check("post_rst_rd", pcpi_rd, 32'd42);
    valid = 1'b0;
    tick(); tick();
    $display("txn reset mid-busy done");

    // Random traffic, checked by the model on every cycle.
    for (int ep = 0; ep < 150; ep++) begin
      tmp = $urandom;
      case ($urandom_range(0, 3))
        0: inst = {tmp[31:7], 7'h53};
        1: inst = {7'h01, tmp[24:7], 7'h33};
        2: inst = {tmp[31:7], 7'h33};
        default: inst = tmp;
      endcase
      rs1 = $urandom; rs2 = $urandom;
      len    = $urandom_range(1, 90);
      gap    = $urandom_range(1, 3);
      quiet  = ($urandom_range(0, 3) == 0);
      do_rst = ((ep % 25) == 12);
      valid  = 1'b1;
      for (int j = 0; j < len + gap; j++) begin
        if (j == len) valid = 1'b0;
        rst_n     = !(do_rst && j == len / 2);
        slv_ready = quiet ? 2'b00 : {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
        slv_wr    = 2'($urandom);
        slv_rd    = {$urandom, $urandom};
        tick();
      end
      rst_n = 1'b1;
      $display("txn rand %0d inst=%h len=%0d quiet=%0d rst=%0d", ep, inst, len, quiet, do_rst);
    end
    valid = 1'b0; slv_ready = 2'b00;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
